loa_adder_arbiter: RTL

- Shares one loa_adder instance among NUM_REQ requesters, for example PE-column partial-sum ports in the approximate TPU.
- Uses round-robin arbitration with valid/ready handshakes on every request port and on the single result port.
- Registers the adder output in a one-entry result stage. The result carries the winning requester's ID so downstream logic can route it back.

---
 rtl/loa_adder_arbiter.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/loa_adder_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : loa_adder_arbiter (plus helper loa_adder)
//  Purpose  : Shares one lower-part-OR approximate adder among NUM_REQ
//             requesters. Arbitration is round-robin with valid/ready
//             handshakes. The sum is registered in a one-entry result stage
//             together with the ID of the requester that produced it.
//  Ports    : clk, rst            - clock, synchronous active-high reset
//             req_valid/req_ready - per-requester handshake (one-hot ready)
//             req_a/req_b         - packed operands, requester i at
//                                   [i*ADDER_LENGTH +: ADDER_LENGTH]
//             res_valid/res_ready - result handshake
//             res_sum/res_id      - registered LOA sum and its requester ID
//             busy                - result pending or any request pending
//             stats_clr/grant_cnt - only when LOA_ARB_STATS_EN is defined:
//                                   synchronous counter clear and per-
//                                   requester saturating 16-bit grant counts
//  Options  : `define LOA_ARB_STATS_EN to add the grant counters
//  Revision : 1.0 - initial release
// ============================================================================

// Lower-part-OR adder: the low IMPRECISE_PART bits are a|b. The upper part
// is an exact add whose carry-in is the AND of the top imprecise bits.
module loa_adder #(
  parameter int ADDER_LENGTH   = 16,
  parameter int IMPRECISE_PART = 8
) (
  input  logic [ADDER_LENGTH-1:0] a,
  input  logic [ADDER_LENGTH-1:0] b,
  output logic [ADDER_LENGTH:0]   sum
);
  localparam int UP_W = ADDER_LENGTH - IMPRECISE_PART;

  logic            w_carry_in;
  logic [UP_W:0]   w_upper;

  assign w_carry_in = a[IMPRECISE_PART-1] & b[IMPRECISE_PART-1];
  assign w_upper    = {1'b0, a[ADDER_LENGTH-1:IMPRECISE_PART]}
                    + {1'b0, b[ADDER_LENGTH-1:IMPRECISE_PART]}
                    + {{UP_W{1'b0}}, w_carry_in};
  assign sum        = {w_upper, a[IMPRECISE_PART-1:0] | b[IMPRECISE_PART-1:0]};
endmodule

module loa_adder_arbiter #(
  parameter  int NUM_REQ        = 4,
  parameter  int ADDER_LENGTH   = 16,
  parameter  int IMPRECISE_PART = 8,
  localparam int ID_W           = $clog2(NUM_REQ)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ*ADDER_LENGTH-1:0] req_a,
  input  logic [NUM_REQ*ADDER_LENGTH-1:0] req_b,
  output logic                            res_valid,
  input  logic                            res_ready,
  output logic [ADDER_LENGTH:0]           res_sum,
  output logic [ID_W-1:0]                 res_id,
  output logic                            busy
`ifdef LOA_ARB_STATS_EN
  ,
  input  logic                            stats_clr,
  output logic [NUM_REQ*16-1:0]           grant_cnt
`endif
);
  // One extra bit so rr_ptr + offset never overflows before the wrap.
  localparam int CW = ID_W + 1;

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t                  state_q;
  state_t                  state_d;
  logic [ID_W-1:0]         rr_ptr;
  logic [ID_W-1:0]         w_ptr_next;
  logic                    w_slot_free;
  logic                    w_found;
  logic [ID_W-1:0]         w_gnt_idx;
  logic [CW-1:0]           w_cand;
  logic                    w_grant;
  logic [ADDER_LENGTH-1:0] w_a;
  logic [ADDER_LENGTH-1:0] w_b;
  logic [ADDER_LENGTH:0]   w_sum;

  // The result slot can take a new sum when empty, or when the held sum is
  // leaving this cycle (back-to-back overwrite).
  assign w_slot_free = (state_q == ST_EMPTY) | res_ready;

  // Round-robin search starting at rr_ptr. Depends only on req_valid and
  // rr_ptr, so there is no path from operands to ready.
  always_comb begin
    w_found   = 1'b0;
    w_gnt_idx = '0;
    w_cand    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_cand = {1'b0, rr_ptr} + CW'(k);
      if (w_cand >= CW'(NUM_REQ)) begin
        w_cand = w_cand - CW'(NUM_REQ);
      end
      if (!w_found && req_valid[w_cand[ID_W-1:0]]) begin
        w_found   = 1'b1;
        w_gnt_idx = w_cand[ID_W-1:0];
      end
    end
  end

  // Ready is forced low during reset so nothing is accepted and then lost.
  assign w_grant = w_found & w_slot_free & ~rst;

  always_comb begin
    req_ready = '0;
    if (w_grant) begin
      req_ready[w_gnt_idx] = 1'b1;
    end
  end

  assign w_ptr_next = (w_gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;

  // Operand mux feeding the single shared adder.
  assign w_a = req_a[w_gnt_idx*ADDER_LENGTH +: ADDER_LENGTH];
  assign w_b = req_b[w_gnt_idx*ADDER_LENGTH +: ADDER_LENGTH];

  loa_adder #(
    .ADDER_LENGTH   (ADDER_LENGTH),
    .IMPRECISE_PART (IMPRECISE_PART)
  ) u_loa_adder (
    .a   (w_a),
    .b   (w_b),
    .sum (w_sum)
  );

  // Result-stage state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (w_grant) state_d = ST_FULL;
      ST_FULL:  if (res_ready && !w_grant) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
  end

  // Result data and pointer only move on a grant, so a stalled output keeps
  // res_sum/res_id stable and the pointer frozen.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_sum <= '0;
      res_id  <= '0;
      rr_ptr  <= '0;
    end else if (w_grant) begin
      res_sum <= w_sum;
      res_id  <= w_gnt_idx;
      rr_ptr  <= w_ptr_next;
    end
  end

  assign res_valid = (state_q == ST_FULL);
  assign busy      = res_valid | (|req_valid);

`ifdef LOA_ARB_STATS_EN
  generate
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_cnt
      logic [15:0] cnt;
      // Clear wins over a same-cycle increment; counting stops at all-ones.
      always_ff @(posedge clk) begin
        if (rst || stats_clr) begin
          cnt <= '0;
        end else if (req_valid[i] && req_ready[i] && (cnt != 16'hFFFF)) begin
          cnt <= cnt + 16'd1;
        end
      end
      assign grant_cnt[i*16 +: 16] = cnt;
    end
  endgenerate
`endif

endmodule
`default_nettype wire
